// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one byte per frame from a transmit FIFO and shifts it out (start, data LSB first, parity, stop).
// Line falls 3 cycles after the start condition is seen; FIFO_Empty/BIST_Mode hold the block idle between frames, never mid-frame.
module uart_tx_serializer #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] Tx_Data,
  input  logic                 FIFO_Empty,
  input  logic                 BIST_Mode,
  output logic                 Pop_Data,
  output logic                 Tx,
  output logic                 Tx_Busy,
  output logic                 Tx_Done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t                state, state_nxt;
  logic [BAUD_W-1:0]     baud_cnt, baud_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0]  shift, shift_nxt;
  logic                  par_bit, par_nxt;
  logic                  tx_nxt, pop_nxt, busy_nxt, done_nxt;
  logic                  start_ok, baud_end;

  assign start_ok = !FIFO_Empty && !BIST_Mode;
  assign baud_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      Tx       <= 1'b1;
      Pop_Data <= 1'b0;
      Tx_Busy  <= 1'b0;
      Tx_Done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      par_bit  <= par_nxt;
      Tx       <= tx_nxt;
      Pop_Data <= pop_nxt;
      Tx_Busy  <= busy_nxt;
      Tx_Done  <= done_nxt;
    end
  end

  // Tx is registered from the current state, so the line trails the FSM by one cycle
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    par_nxt   = par_bit;
    tx_nxt    = 1'b1;
    pop_nxt   = 1'b0;
    busy_nxt  = Tx_Busy;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (start_ok) begin
          state_nxt = POP;
          pop_nxt   = 1'b1;
          busy_nxt  = 1'b1;
        end
      end

      POP: state_nxt = LOAD;

      LOAD: begin
        shift_nxt = Tx_Data;
        par_nxt   = (PARITY == 2) ? ~^Tx_Data : ^Tx_Data;
        baud_nxt  = '0;
        bit_nxt   = '0;
        state_nxt = START;
      end

      START: begin
        tx_nxt = 1'b0;
        if (baud_end) begin
          baud_nxt  = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end

      DATA: begin
        tx_nxt = shift[0];
        if (baud_end) begin
          baud_nxt  = '0;
          shift_nxt = {1'b0, shift[DATA_BITS-1:1]};
          if (bit_cnt == DATA_LAST) begin
            bit_nxt   = '0;
            state_nxt = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end

      PAR: begin
        tx_nxt = par_bit;
        if (baud_end) begin
          baud_nxt  = '0;
          state_nxt = STOP;
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end

      STOP: begin
        tx_nxt = 1'b1;
        if (baud_end) begin
          baud_nxt = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_nxt  = '0;
            done_nxt = 1'b1;
            // back-to-back frames skip IDLE so the gap is only POP + LOAD
            if (start_ok) begin
              state_nxt = POP;
              pop_nxt   = 1'b1;
              busy_nxt  = 1'b1;
            end else begin
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
            end
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: three instances (even parity, odd parity, no parity with two stop bits), CLKS_PER_BIT=4.
module tb_uart_tx_serializer;

  localparam int BIT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       bist;
  logic       empty [3];
  logic       pop   [3];
  logic       tx    [3];
  logic       busy  [3];
  logic       done  [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.DATA_BITS(8), .CLKS_PER_BIT(BIT), .PARITY(1), .STOP_BITS(1)) dut_even (
    .clk(clk), .rst(rst), .Tx_Data(tx_data), .FIFO_Empty(empty[0]), .BIST_Mode(bist),
    .Pop_Data(pop[0]), .Tx(tx[0]), .Tx_Busy(busy[0]), .Tx_Done(done[0]));

  uart_tx_serializer #(.DATA_BITS(8), .CLKS_PER_BIT(BIT), .PARITY(2), .STOP_BITS(1)) dut_odd (
    .clk(clk), .rst(rst), .Tx_Data(tx_data), .FIFO_Empty(empty[1]), .BIST_Mode(bist),
    .Pop_Data(pop[1]), .Tx(tx[1]), .Tx_Busy(busy[1]), .Tx_Done(done[1]));

  uart_tx_serializer #(.DATA_BITS(8), .CLKS_PER_BIT(BIT), .PARITY(0), .STOP_BITS(2)) dut_two_stop (
    .clk(clk), .rst(rst), .Tx_Data(tx_data), .FIFO_Empty(empty[2]), .BIST_Mode(bist),
    .Pop_Data(pop[2]), .Tx(tx[2]), .Tx_Busy(busy[2]), .Tx_Done(done[2]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string what, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%b expected=%b", tag, what, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int sel);
    chk(tag, "tx", tx[sel], 1'b1);
    chk(tag, "pop", pop[sel], 1'b0);
    chk(tag, "busy", busy[sel], 1'b0);
    chk(tag, "done", done[sel], 1'b0);
  endtask

  // Entered one cycle before the start-condition edge k (or at k+1ns when chained,
  // the pop having been checked by the previous frame). bits[i] is line bit i.
  task automatic run_frame(input string tag, input int sel, input logic [10:0] bits,
                           input int nbits, input bit chained, input bit exp_next,
                           input bit clear_empty, input logic [7:0] next_data,
                           input int bist_at);
    bit last;
    if (!chained) begin
      step();
      chk(tag, "pop_k", pop[sel], 1'b1);
      chk(tag, "busy_k", busy[sel], 1'b1);
      chk(tag, "tx_k", tx[sel], 1'b1);
    end
    if (clear_empty) empty[sel] = 1'b1;
    step();
    chk(tag, "pop_k1", pop[sel], 1'b0);
    chk(tag, "tx_k1", tx[sel], 1'b1);
    chk(tag, "busy_k1", busy[sel], 1'b1);
    step();
    chk(tag, "tx_k2", tx[sel], 1'b1);
    chk(tag, "busy_k2", busy[sel], 1'b1);
    tx_data = next_data;
    for (int t = 0; t < nbits * BIT; t++) begin
      step();
      if (t == bist_at) bist = 1'b1;
      last = (t == nbits * BIT - 1);
      chk(tag, "tx", tx[sel], bits[t / BIT]);
      chk(tag, "done", done[sel], last);
      chk(tag, "busy", busy[sel], last ? exp_next : 1'b1);
      chk(tag, "pop", pop[sel], last ? exp_next : 1'b0);
    end
  endtask

  initial begin
    rst     = 1'b0;
    tx_data = 8'h00;
    bist    = 1'b0;
    for (int i = 0; i < 3; i++) empty[i] = 1'b1;
    #1 rst = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) chk_idle("reset", i);
    step();
    step();
    rst = 1'b0;

    repeat (100) begin
      step();
      for (int i = 0; i < 3; i++) chk_idle("empty", i);
    end

    // 0xA5 even parity: start 0, 1010 0101 LSB first, parity 0, stop 1
    tx_data = 8'hA5;
    empty[0] = 1'b0;
    run_frame("a5_even", 0, 11'h54A, 11, 1'b0, 1'b0, 1'b1, 8'h00, -1);
    step();
    chk_idle("a5_end", 0);

    tx_data = 8'hFF;
    empty[1] = 1'b0;
    run_frame("ff_odd", 1, 11'h7FE, 11, 1'b0, 1'b0, 1'b1, 8'h00, -1);
    step();
    chk_idle("ff_end", 1);

    tx_data = 8'h00;
    empty[2] = 1'b0;
    run_frame("00_2stop", 2, 11'h600, 11, 1'b0, 1'b0, 1'b1, 8'h00, -1);
    step();
    chk_idle("00_end", 2);

    tx_data = 8'h01;
    empty[0] = 1'b0;
    run_frame("q01", 0, 11'h602, 11, 1'b0, 1'b1, 1'b0, 8'h80, -1);
    run_frame("q80", 0, 11'h700, 11, 1'b1, 1'b1, 1'b0, 8'h3C, -1);
    run_frame("q3c", 0, 11'h478, 11, 1'b1, 1'b0, 1'b1, 8'h00, -1);
    step();
    chk_idle("q_end", 0);

    tx_data = 8'h55;
    empty[0] = 1'b0;
    run_frame("bist55", 0, 11'h4AA, 11, 1'b0, 1'b0, 1'b0, 8'h37, 20);
    repeat (10) begin
      step();
      chk_idle("bist_hold", 0);
    end
    bist = 1'b0;
    step();
    chk("bist_release", "pop", pop[0], 1'b1);
    chk("bist_release", "busy", busy[0], 1'b1);

    // 0x37 has data bit 3 low, so a high line after reset proves the abort
    step();
    step();
    repeat (18) step();
    chk("abort_pre", "tx", tx[0], 1'b0);
    chk("abort_pre", "busy", busy[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_idle("abort_async", 0);
    step();
    chk_idle("abort_hold", 0);
    tx_data = 8'hC3;
    rst = 1'b0;
    run_frame("post_rst", 0, 11'h586, 11, 1'b0, 1'b0, 1'b1, 8'h00, -1);
    step();
    chk_idle("post_end", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
